vga_box_renderer: RTL and testbench
===================================

VGA_BOX_RENDERER -- requirements
Module: vga_box_renderer

Interface
REQ-001 Parameter H_ACT_START, default 384, first active hcount.
REQ-002 Parameter V_ACT_START, default 31, first active vcount.
REQ-003 Parameter ACT_W, default 1440, active width in pixels.
REQ-004 Parameter ACT_H, default 900, active height in lines.
REQ-005 Parameter BOX, default 64, box edge length in pixels.
REQ-006 Parameter STEP, default 2, box movement per frame per axis.
REQ-007 clk  in  1  pixel clock; all logic on rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 hcount  in  11  horizontal counter from the timing stage.
REQ-010 vcount  in  10  vertical counter from the timing stage.
REQ-011 display_region  in  1  high inside the active area.
REQ-012 hsync_in / vsync_in  in  1 each  active-low syncs from the timing stage.
REQ-013 sw  in  3  raw board switches: [0] red background, [1] green background, [2] motion enable.
REQ-014 pix_r / pix_g / pix_b  out  4 each  registered pixel colour.
REQ-015 hsync / vsync  out  1 each  registered syncs, aligned with the pix_* outputs.

Function
REQ-016 sw SHALL pass through a 2-flop synchroniser before any use.
REQ-017 Pipeline SHALL be exactly 2 clk: stage 1 registers x=hcount-H_ACT_START, y=vcount-V_ACT_START (11/10 bit, wrap ignored outside active area), display_region and both syncs; stage 2 registers the colour and the delayed syncs.
REQ-018 hsync/vsync SHALL equal hsync_in/vsync_in delayed by exactly 2 clk.
REQ-019 frame_tick SHALL pulse for 1 clk when registered vsync_in goes 1->0.
REQ-020 Box position bx (0..ACT_W-BOX), by (0..ACT_H-BOX) and direction dx, dy (1 = increasing) SHALL change only on frame_tick with synced sw[2]=1.
REQ-021 Per axis on update: if increasing and pos+STEP >= max, pos<=max and dir<=0; if decreasing and pos <= STEP, pos<=0 and dir<=1; otherwise pos<=pos±STEP.
REQ-022 A position at exactly 0 or max on a tick SHALL reverse direction and move by no more than the clamped amount; the position SHALL never leave its range.
REQ-023 hit SHALL be true when bx <= x < bx+BOX and by <= y < by+BOX, using the stage-1 x/y and the current bx/by.
REQ-024 Colour: display_region=0 -> all channels 0; hit -> R=G=B=4'hF; otherwise R=sw[0]?4'h4:0, G=sw[1]?4'h4:0, B=0.
REQ-025 Because the vsync edge lies in blanking, a position update SHALL never change box geometry within a visible frame.
REQ-026 sw[2]=0 SHALL freeze bx/by/dx/dy. Returning sw[2] to 1 SHALL resume from the held state.

Reset
REQ-027 With rst_n low: bx=by=0, dx=dy=1, synchroniser and pipeline flops 0 except sync flops=1, pix_*=0, hsync=vsync=1.
REQ-028 Reset asserted mid-frame SHALL force REQ-027 values immediately. After release, the first frame_tick SHALL need a fresh 1->0 vsync_in edge.

Structure
REQ-029 Shared package vga_pkg SHALL hold the timing constants (H_ACT_START, V_ACT_START, ACT_W, ACT_H, H_TOTAL=1904) used by this block and the timing stage.
REQ-030 Per-axis bounce logic SHALL be one sub-module, vga_bounce_axis (params MAX, STEP; ports clk, rst_n, en, pos, dir), instantiated twice.

Verification
REQ-031 Reset then hcount=384, vcount=31, display_region=1, sw=3'b000 -> 2 clk later pix=F/F/F (box at 0,0).
REQ-032 hcount=384+64, vcount=31, sw=3'b011 -> pix_r=4, pix_g=4, pix_b=0; display_region=0 -> all zero.
REQ-033 sw=3'b100, 5 vsync falling edges -> bx=by=10. With bx forced near max: 688 ticks -> bx=1376, dx=0; next tick -> bx=1374.
REQ-034 Toggle hsync_in/vsync_in with a random pattern -> outputs equal inputs delayed by exactly 2 clk.
REQ-035 sw[2]=1 for 3 ticks, then 0 for 3 ticks -> bx=by=6, unchanged during the 0 period.
REQ-036 rst_n pulsed low mid-line with bx=100 -> bx=0 and pix=0 asynchronously; no tick until the next vsync_in fall.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and small colour helpers used by the
// timing stage and the box renderer.
package vga_pkg;

  // Timing of the 1440x900 mode driven by the timing stage.
  localparam int H_ACT_START = 384;
  localparam int V_ACT_START = 31;
  localparam int ACT_W       = 1440;
  localparam int ACT_H       = 900;
  localparam int H_TOTAL     = 1904;

  // Width of box position registers; wide enough for either axis.
  localparam int POS_W = 11;

  // Colour levels.
  localparam logic [3:0] BG_LEVEL = 4'h4;
  localparam logic [3:0] FG_LEVEL = 4'hF;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Background colour selected by the red/green switches.
  function automatic rgb_t bg_colour(input logic red_en, input logic green_en);
    rgb_t c;
    c.r = red_en   ? BG_LEVEL : 4'h0;
    c.g = green_en ? BG_LEVEL : 4'h0;
    c.b = 4'h0;
    return c;
  endfunction

  // Solid box colour.
  function automatic rgb_t box_colour();
    rgb_t c;
    c.r = FG_LEVEL;
    c.g = FG_LEVEL;
    c.b = FG_LEVEL;
    return c;
  endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: a position that moves by STEP on each
// enabled update and reflects at 0 and MAX, never leaving [0, MAX].
module vga_bounce_axis #(
  parameter int MAX  = 1376,
  parameter int STEP = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  output logic [vga_pkg::POS_W-1:0] pos,
  output logic                     dir
);
  import vga_pkg::*;

  localparam logic [POS_W-1:0] MAX_P  = POS_W'(MAX);
  localparam logic [POS_W-1:0] STEP_P = POS_W'(STEP);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [POS_W:0]   pos_up;

  // One extra bit so pos+STEP near the top of the range cannot wrap.
  assign pos_up = {1'b0, pos_q} + {1'b0, STEP_P};

  // Next position/direction: move, or clamp to the edge and reverse.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (en) begin
      if (dir_q) begin
        if (pos_up >= {1'b0, MAX_P}) begin
          pos_d = MAX_P;
          dir_d = 1'b0;
        end else begin
          pos_d = pos_up[POS_W-1:0];
        end
      end else begin
        if (pos_q <= STEP_P) begin
          pos_d = '0;
          dir_d = 1'b1;
        end else begin
          pos_d = pos_q - STEP_P;
        end
      end
    end
  end

  // Position/direction state; starts at 0 heading upward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;

endmodule

// File: rtl/vga_box_renderer.sv
// Draws a solid white box that bounces around the active area over a
// switch-selected background. Two-clock pipeline from the timing-stage
// counters/syncs to the registered pixel and sync outputs.
module vga_box_renderer #(
  parameter int H_ACT_START = vga_pkg::H_ACT_START,
  parameter int V_ACT_START = vga_pkg::V_ACT_START,
  parameter int ACT_W       = vga_pkg::ACT_W,
  parameter int ACT_H       = vga_pkg::ACT_H,
  parameter int BOX         = 64,
  parameter int STEP        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        display_region,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  sw,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        hsync,
  output logic        vsync
);
  import vga_pkg::*;

  localparam logic [10:0]    H_OFF   = 11'(H_ACT_START);
  localparam logic [9:0]     V_OFF   = 10'(V_ACT_START);
  localparam logic [POS_W:0] BOX_EXT = (POS_W+1)'(BOX);

  // Switch synchroniser
  logic [2:0] sw_meta_q, sw_meta_d;
  logic [2:0] sw_sync_q, sw_sync_d;

  // Stage 1
  logic [10:0] x_p1_q, x_p1_d;
  logic [9:0]  y_p1_q, y_p1_d;
  logic        de_p1_q, de_p1_d;
  logic        hs_p1_q, hs_p1_d;
  logic        vs_p1_q, vs_p1_d;
  // live_* mark that the matching vsync flop holds a sampled input rather
  // than its reset value, so a reset cannot fake a falling edge.
  logic        live_p1_q, live_p1_d;
  logic        live_p2_q, live_p2_d;

  // Stage 2
  rgb_t        pix_p2_q, pix_p2_d;
  logic        hs_p2_q, hs_p2_d;
  logic        vs_p2_q, vs_p2_d;

  // Box state and hit detection
  logic [POS_W-1:0] bx, by;
  logic             dx, dy;
  logic             frame_tick;
  logic             move_en;
  logic             hit;
  logic [POS_W:0]   x_ext, y_ext, bx_ext, by_ext;

  // Falling edge of the registered vsync; lies in vertical blanking, so the
  // box only moves between visible frames.
  assign frame_tick = live_p2_q & vs_p2_q & ~vs_p1_q;
  assign move_en    = frame_tick & sw_sync_q[2];

  vga_bounce_axis #(
    .MAX  (ACT_W - BOX),
    .STEP (STEP)
  ) u_bx (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (move_en),
    .pos   (bx),
    .dir   (dx)
  );

  vga_bounce_axis #(
    .MAX  (ACT_H - BOX),
    .STEP (STEP)
  ) u_by (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (move_en),
    .pos   (by),
    .dir   (dy)
  );

  // Box membership of the stage-1 pixel, widened so bx+BOX cannot wrap.
  always_comb begin
    x_ext  = {1'b0, x_p1_q};
    y_ext  = {2'b00, y_p1_q};
    bx_ext = {1'b0, bx};
    by_ext = {1'b0, by};
    hit    = (x_ext >= bx_ext) && (x_ext < bx_ext + BOX_EXT) &&
             (y_ext >= by_ext) && (y_ext < by_ext + BOX_EXT);
  end

  // Next-state values for the synchroniser and both pipeline stages.
  always_comb begin
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;

    // ---- stage 1: active-area coordinates and delayed controls ----
    x_p1_d    = hcount - H_OFF;
    y_p1_d    = vcount - V_OFF;
    de_p1_d   = display_region;
    hs_p1_d   = hsync_in;
    vs_p1_d   = vsync_in;
    live_p1_d = 1'b1;
    live_p2_d = live_p1_q;

    // ---- stage 2: colour and output syncs ----
    pix_p2_d = '0;
    if (de_p1_q) begin
      if (hit) begin
        pix_p2_d = box_colour();
      end else begin
        pix_p2_d = bg_colour(sw_sync_q[0], sw_sync_q[1]);
      end
    end
    hs_p2_d = hs_p1_q;
    vs_p2_d = vs_p1_q;
  end

  // Two-flop switch synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  // Stage-1 registers; syncs idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p1_q    <= '0;
      y_p1_q    <= '0;
      de_p1_q   <= 1'b0;
      hs_p1_q   <= 1'b1;
      vs_p1_q   <= 1'b1;
      live_p1_q <= 1'b0;
      live_p2_q <= 1'b0;
    end else begin
      x_p1_q    <= x_p1_d;
      y_p1_q    <= y_p1_d;
      de_p1_q   <= de_p1_d;
      hs_p1_q   <= hs_p1_d;
      vs_p1_q   <= vs_p1_d;
      live_p1_q <= live_p1_d;
      live_p2_q <= live_p2_d;
    end
  end

  // Stage-2 output registers; black pixel and idle-high syncs in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_p2_q <= '0;
      hs_p2_q  <= 1'b1;
      vs_p2_q  <= 1'b1;
    end else begin
      pix_p2_q <= pix_p2_d;
      hs_p2_q  <= hs_p2_d;
      vs_p2_q  <= vs_p2_d;
    end
  end

  assign pix_r = pix_p2_q.r;
  assign pix_g = pix_p2_q.g;
  assign pix_b = pix_p2_q.b;
  assign hsync = hs_p2_q;
  assign vsync = vs_p2_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Scoreboard bench for vga_box_renderer: each driven cycle pushes the
// expected registered outputs, a negedge monitor pops and compares.
module tb_vga_box_renderer;

  localparam int H0    = 384;
  localparam int V0    = 31;
  localparam int BOX   = 64;
  localparam int STEP  = 2;
  localparam int MAX_X = 1440 - 64;
  localparam int MAX_Y = 900 - 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        display_region;
  logic        hsync_in, vsync_in;
  logic [2:0]  sw;
  logic [3:0]  pix_r, pix_g, pix_b;
  logic        hsync, vsync;

  always #5 clk = ~clk;

  vga_box_renderer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hcount         (hcount),
    .vcount         (vcount),
    .display_region (display_region),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .sw             (sw),
    .pix_r          (pix_r),
    .pix_g          (pix_g),
    .pix_b          (pix_b),
    .hsync          (hsync),
    .vsync          (vsync)
  );

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
  } exp_t;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        de;
    logic        hs;
    logic        vs;
    logic [2:0]  sw;
    logic        live;
  } in_t;

  exp_t exp_q[$];
  in_t  p1, p2;          // inputs applied one and two edges ago
  int   bx_m, by_m;
  bit   dx_m, dy_m;
  int   checks = 0;
  int   errors = 0;

  function automatic in_t idle_in();
    in_t t;
    t    = '0;
    t.hs = 1'b1;
    t.vs = 1'b1;
    return t;
  endfunction

  task automatic model_reset();
    p1 = idle_in();
    p2 = idle_in();
    bx_m = 0; by_m = 0; dx_m = 1'b1; dy_m = 1'b1;
    exp_q.delete();
  endtask

  task automatic bounce(inout int p, inout bit d, input int mx);
    if (d) begin
      if (p + STEP >= mx) begin p = mx; d = 1'b0; end
      else p = p + STEP;
    end else begin
      if (p <= STEP) begin p = 0; d = 1'b1; end
      else p = p - STEP;
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Called at a negedge: drive one cycle, predict outputs after the edge.
  task automatic step(input logic [10:0] h, input logic [9:0] v, input logic de,
                      input logic hs, input logic vs, input logic [2:0] s);
    in_t  cur;
    exp_t e;
    int   x, y;
    bit   hit;
    hcount = h; vcount = v; display_region = de;
    hsync_in = hs; vsync_in = vs; sw = s;
    cur.h = h; cur.v = v; cur.de = de; cur.hs = hs; cur.vs = vs;
    cur.sw = s; cur.live = 1'b1;
    @(posedge clk);
    x = (int'(p1.h) - H0) & 2047;
    y = (int'(p1.v) - V0) & 1023;
    hit = (x >= bx_m) && (x < bx_m + BOX) && (y >= by_m) && (y < by_m + BOX);
    e.hs = p1.hs;
    e.vs = p1.vs;
    if (!p1.de) begin
      e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
    end else if (hit) begin
      e.r = 4'hF; e.g = 4'hF; e.b = 4'hF;
    end else begin
      e.r = p2.sw[0] ? 4'h4 : 4'h0;
      e.g = p2.sw[1] ? 4'h4 : 4'h0;
      e.b = 4'h0;
    end
    exp_q.push_back(e);
    if (p2.live && p2.vs && !p1.vs && p2.sw[2]) begin
      bounce(bx_m, dx_m, MAX_X);
      bounce(by_m, dy_m, MAX_Y);
    end
    p2 = p1;
    p1 = cur;
    @(negedge clk);
  endtask

  task automatic probe(output logic [10:0] h, output logic [9:0] v, output logic de);
    if ($urandom_range(0, 9) == 0) begin
      h = 11'($urandom_range(0, 2047));
      v = 10'($urandom_range(0, 1023));
    end else begin
      h = 11'(H0 + bx_m + int'($urandom_range(0, 79)) - 8);
      v = 10'(V0 + by_m + int'($urandom_range(0, 79)) - 8);
    end
    de = ($urandom_range(0, 7) != 0);
  endtask

  // One vsync falling edge, held low long enough for the update to land.
  task automatic tick(input logic [2:0] s);
    logic [10:0] h;
    logic [9:0]  v;
    logic        de;
    probe(h, v, de); step(h, v, de, 1'($urandom_range(0, 1)), 1'b1, s);
    probe(h, v, de); step(h, v, de, 1'($urandom_range(0, 1)), 1'b0, s);
    probe(h, v, de); step(h, v, de, 1'($urandom_range(0, 1)), 1'b0, s);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hcount = '0; vcount = '0; display_region = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; sw = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the oldest prediction.
  exp_t got;
  exp_t want;
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {pix_r, pix_g, pix_b, hsync, vsync};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pix_out: got r=%h g=%h b=%h hs=%b vs=%b expected r=%h g=%h b=%h hs=%b vs=%b",
                 got.r, got.g, got.b, got.hs, got.vs,
                 want.r, want.g, want.b, want.hs, want.vs);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] h;
    logic [9:0]  v;
    logic        de;

    rst_n = 1'b0;
    hcount = '0; vcount = '0; display_region = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; sw = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_pix", int'({pix_r, pix_g, pix_b}), 0);
    chk("reset_syncs", int'({hsync, vsync}), 3);
    chk("reset_bx", int'(dut.bx), 0);
    chk("reset_dx", int'(dut.dx), 1);
    rst_n = 1'b1;

    // Box at origin covers the first active pixel.
    repeat (3) step(11'd384, 10'd31, 1'b1, 1'b1, 1'b1, 3'b000);
    // Just right of the box: background only, then blanked.
    repeat (3) step(11'd448, 10'd31, 1'b1, 1'b1, 1'b1, 3'b011);
    repeat (2) step(11'd448, 10'd31, 1'b0, 1'b1, 1'b1, 3'b011);
    repeat (2) step(11'd400, 10'd40, 1'b0, 1'b1, 1'b1, 3'b011);
    step(11'd447, 10'd94, 1'b1, 1'b1, 1'b1, 3'b010);
    step(11'd447, 10'd95, 1'b1, 1'b1, 1'b1, 3'b001);
    repeat (2) step(11'd383, 10'd31, 1'b1, 1'b1, 1'b1, 3'b001);

    // Random sync patterns, colours and motion.
    for (int i = 0; i < 250; i++) begin
      probe(h, v, de);
      step(h, v, de, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)));
    end

    // Motion from reset, through the right-hand bounce.
    do_reset();
    for (int i = 0; i < 5; i++) tick(3'b100);
    chk("bx_5ticks", int'(dut.bx), 10);
    chk("by_5ticks", int'(dut.by), 10);
    for (int i = 5; i < 688; i++) tick(3'b100);
    chk("bx_688ticks", int'(dut.bx), 1376);
    chk("dx_688ticks", int'(dut.dx), 0);
    chk("by_688ticks", int'(dut.by), by_m);
    tick(3'b100);
    chk("bx_689ticks", int'(dut.bx), 1374);

    // Freeze and resume.
    do_reset();
    for (int i = 0; i < 3; i++) tick(3'b100);
    chk("bx_run3", int'(dut.bx), 6);
    chk("by_run3", int'(dut.by), 6);
    for (int i = 0; i < 3; i++) begin
      tick(3'b000);
      chk("bx_frozen", int'(dut.bx), 6);
      chk("by_frozen", int'(dut.by), 6);
    end
    tick(3'b100);
    chk("bx_resume", int'(dut.bx), 8);

    // Asynchronous reset in the middle of a line.
    do_reset();
    for (int i = 0; i < 50; i++) tick(3'b100);
    chk("bx_before_rst", int'(dut.bx), 100);
    repeat (2) step(11'd484, 10'd131, 1'b1, 1'b1, 1'b0, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pix", int'({pix_r, pix_g, pix_b}), 0);
    chk("async_syncs", int'({hsync, vsync}), 3);
    chk("async_bx", int'(dut.bx), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      probe(h, v, de);
      step(h, v, de, 1'b1, 1'b0, 3'b100);
    end
    chk("no_tick_after_rst", int'(dut.bx), 0);
    tick(3'b100);
    chk("first_tick_after_rst", int'(dut.bx), 2);
    step(11'd384, 10'd31, 1'b1, 1'b1, 1'b1, 3'b100);
    step(11'd384, 10'd31, 1'b1, 1'b1, 1'b1, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
